// File: rtl/dds_wave_meter.sv
// Per-cycle measurement of the DDS sample stream: period between rising midscale crossings
// (with hysteresis) plus peak max/min over that period, and a no-signal timeout flag.
module dds_wave_meter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MID     = 128,
  parameter int unsigned HYST    = 8,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] din,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] vmax,
  output logic [DATA_W-1:0] vmin,
  output logic              no_signal
);

  localparam logic [DATA_W-1:0] HI        = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO        = DATA_W'(MID - HYST);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    StSync = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] run_max_q, run_max_d;
  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic              meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0] vmax_q, vmax_d;
  logic [DATA_W-1:0] vmin_q, vmin_d;
  logic              no_signal_q, no_signal_d;

  logic              crossing;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StSync;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      meas_valid_q <= 1'b0;
      period_q     <= '0;
      vmax_q       <= '0;
      vmin_q       <= '0;
      no_signal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      meas_valid_q <= meas_valid_d;
      period_q     <= period_d;
      vmax_q       <= vmax_d;
      vmin_q       <= vmin_d;
      no_signal_q  <= no_signal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    meas_valid_d = 1'b0;
    period_d     = period_q;
    vmax_d       = vmax_q;
    vmin_d       = vmin_q;
    no_signal_d  = no_signal_q;
    crossing     = 1'b0;

    if (sample_en) begin
      case (state_q)
        StSync: if (din <= LO) state_d = StLow;
        StLow: begin
          if (din >= HI) begin
            state_d  = StHigh;
            crossing = 1'b1;
          end
        end
        StHigh: if (din <= LO) state_d = StLow;
        default: state_d = StSync;
      endcase

      // A crossing takes priority over a timeout on the same sample.
      if (crossing) begin
        if (armed_q) begin
          period_d     = cnt_q;
          vmax_d       = run_max_q;
          vmin_d       = run_min_q;
          meas_valid_d = 1'b1;
          no_signal_d  = 1'b0;
        end
        armed_d   = 1'b1;
        cnt_d     = CNT_ONE;
        run_max_d = din;
        run_min_d = din;
      end else if (cnt_inc == TIMEOUT_C) begin
        no_signal_d = 1'b1;
        state_d     = StSync;
        armed_d     = 1'b0;
        cnt_d       = '0;
      end else begin
        // Counter also runs before the first crossing so a dead input still times out.
        cnt_d = cnt_inc;
        if (armed_q) begin
          if (din > run_max_q) run_max_d = din;
          if (din < run_min_q) run_min_d = din;
        end
      end
    end
  end

  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign vmax       = vmax_q;
  assign vmin       = vmin_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_dds_wave_meter.sv
// Directed self-checking bench for dds_wave_meter (TIMEOUT reduced to 1000).
module tb_dds_wave_meter;

  localparam int unsigned CW = 24;
  localparam int unsigned TO = 1000;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          sample_en = 1'b0;
  logic [7:0]    din = 8'd0;
  logic          meas_valid;
  logic [CW-1:0] period;
  logic [7:0]    vmax;
  logic [7:0]    vmin;
  logic          no_signal;

  int tests_run = 0;
  int tests_failed = 0;

  dds_wave_meter #(
    .DATA_W (8),
    .MID    (128),
    .HYST   (8),
    .CNT_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .sample_en (sample_en),
    .din       (din),
    .meas_valid(meas_valid),
    .period    (period),
    .vmax      (vmax),
    .vmin      (vmin),
    .no_signal (no_signal)
  );

  always #5 sys_clk = ~sys_clk;

  // Present one input for one clock; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic en, input logic [7:0] d);
    sample_en = en;
    din = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step(1'b1, 8'd255);
    sys_rst = 1'b0;
  endtask

  function automatic logic [7:0] sq(input int idx, input int half);
    return ((idx % (2 * half)) < half) ? 8'd0 : 8'd255;
  endfunction

  task automatic test_reset();
    sys_rst = 1'b1;
    step(1'b1, 8'd0);
    step(1'b1, 8'd255);
    sys_rst = 1'b0;
    tests_run++;
    if (meas_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_meas_valid got %b want 0", meas_valid);
    end
    tests_run++;
    if (period !== 24'd0) begin
      tests_failed++; $display("FAIL reset_period got %0d want 0", period);
    end
    tests_run++;
    if (vmax !== 8'd0) begin
      tests_failed++; $display("FAIL reset_vmax got %0d want 0", vmax);
    end
    tests_run++;
    if (vmin !== 8'd0) begin
      tests_failed++; $display("FAIL reset_vmin got %0d want 0", vmin);
    end
    tests_run++;
    if (no_signal !== 1'b0) begin
      tests_failed++; $display("FAIL reset_no_signal got %b want 0", no_signal);
    end
  endtask

  task automatic test_square();
    logic exp;
    do_reset();
    for (int idx = 0; idx < 400; idx++) begin
      step(1'b1, sq(idx, 50));
      exp = (idx >= 150) && (idx % 100 == 50);
      tests_run++;
      if (meas_valid !== exp) begin
        tests_failed++;
        $display("FAIL square_valid idx=%0d got %b want %b", idx, meas_valid, exp);
      end
      if (exp) begin
        tests_run++;
        if (period !== 24'd100 || vmax !== 8'd255 || vmin !== 8'd0) begin
          tests_failed++;
          $display("FAIL square_meas idx=%0d got p=%0d max=%0d min=%0d want p=100 max=255 min=0",
                   idx, period, vmax, vmin);
        end
      end
    end
    tests_run++;
    if (no_signal !== 1'b0) begin
      tests_failed++; $display("FAIL square_no_signal got %b want 0", no_signal);
    end
  endtask

  task automatic test_sawtooth();
    logic exp;
    do_reset();
    for (int idx = 0; idx < 768; idx++) begin
      step(1'b1, 8'(idx % 256));
      exp = (idx >= 256) && (idx % 256 == 136);
      tests_run++;
      if (meas_valid !== exp) begin
        tests_failed++;
        $display("FAIL saw_valid idx=%0d got %b want %b", idx, meas_valid, exp);
      end
      if (exp) begin
        tests_run++;
        if (period !== 24'd256 || vmax !== 8'd255 || vmin !== 8'd0) begin
          tests_failed++;
          $display("FAIL saw_meas idx=%0d got p=%0d max=%0d min=%0d want p=256 max=255 min=0",
                   idx, period, vmax, vmin);
        end
      end
    end
  endtask

  task automatic test_noise();
    logic exp;
    logic [7:0] d;
    int i;
    do_reset();
    for (int idx = 0; idx < 400; idx++) begin
      i = idx % 100;
      if (i < 45)      d = (i % 2 != 0) ? 8'd5   : 8'd0;
      else if (i < 50) d = (i % 2 != 0) ? 8'd133 : 8'd123;
      else if (i < 95) d = (i % 2 != 0) ? 8'd250 : 8'd255;
      else             d = (i % 2 != 0) ? 8'd123 : 8'd133;
      step(1'b1, d);
      exp = (idx >= 150) && (i == 50);
      tests_run++;
      if (meas_valid !== exp) begin
        tests_failed++;
        $display("FAIL noise_valid idx=%0d got %b want %b", idx, meas_valid, exp);
      end
      if (exp) begin
        tests_run++;
        if (period !== 24'd100 || vmax !== 8'd255 || vmin !== 8'd0) begin
          tests_failed++;
          $display("FAIL noise_meas idx=%0d got p=%0d max=%0d min=%0d want p=100 max=255 min=0",
                   idx, period, vmax, vmin);
        end
      end
    end
  endtask

  task automatic test_sparse_en();
    logic exp;
    logic en;
    int s;
    int last_pulse;
    do_reset();
    last_pulse = -1;
    for (int c = 0; c < 1024; c++) begin
      en = (c % 4 == 0);
      s = c / 4;
      step(en, en ? sq(s, 32) : 8'(c * 37));
      exp = en && (s >= 96) && (s % 64 == 32);
      tests_run++;
      if (meas_valid !== exp) begin
        tests_failed++;
        $display("FAIL sparse_valid clk=%0d got %b want %b", c, meas_valid, exp);
      end
      if (exp) begin
        tests_run++;
        if (period !== 24'd64 || vmax !== 8'd255 || vmin !== 8'd0) begin
          tests_failed++;
          $display("FAIL sparse_meas clk=%0d got p=%0d max=%0d min=%0d want p=64 max=255 min=0",
                   c, period, vmax, vmin);
        end
      end
      if (meas_valid === 1'b1) begin
        if (last_pulse >= 0) begin
          tests_run++;
          if (c - last_pulse != 256) begin
            tests_failed++;
            $display("FAIL sparse_spacing got %0d want 256", c - last_pulse);
          end
        end
        last_pulse = c;
      end
    end
  endtask

  task automatic test_timeout();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      step(1'b1, 8'd128);
      seen = seen | (meas_valid === 1'b1);
      if (n == 999) begin
        tests_run++;
        if (no_signal !== 1'b0) begin
          tests_failed++; $display("FAIL timeout_early got %b want 0", no_signal);
        end
      end
      if (n == 1000) begin
        tests_run++;
        if (no_signal !== 1'b1) begin
          tests_failed++; $display("FAIL timeout_set got %b want 1", no_signal);
        end
      end
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_no_pulse got %b want 0", seen);
    end
    for (int idx = 0; idx < 200; idx++) begin
      step(1'b1, sq(idx, 50));
      if (idx == 149) begin
        tests_run++;
        if (no_signal !== 1'b1 || meas_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL timeout_hold got ns=%b mv=%b want ns=1 mv=0", no_signal, meas_valid);
        end
      end
      if (idx == 150) begin
        tests_run++;
        if (no_signal !== 1'b0 || meas_valid !== 1'b1 || period !== 24'd100) begin
          tests_failed++;
          $display("FAIL timeout_clear got ns=%b mv=%b p=%0d want ns=0 mv=1 p=100",
                   no_signal, meas_valid, period);
        end
      end
    end
    // Counter sits at 50 after the last square sample, so 950 more samples reach TIMEOUT.
    for (int n = 1; n <= 950; n++) begin
      step(1'b1, 8'd128);
      if (n == 949) begin
        tests_run++;
        if (no_signal !== 1'b0) begin
          tests_failed++; $display("FAIL timeout2_early got %b want 0", no_signal);
        end
      end
      if (n == 950) begin
        tests_run++;
        if (no_signal !== 1'b1 || period !== 24'd100 || vmax !== 8'd255 || vmin !== 8'd0) begin
          tests_failed++;
          $display("FAIL timeout2_set got ns=%b p=%0d max=%0d min=%0d want ns=1 p=100 max=255 min=0",
                   no_signal, period, vmax, vmin);
        end
      end
    end
  endtask

  task automatic test_cross_wins();
    do_reset();
    step(1'b1, 8'd0);
    for (int n = 0; n < 998; n++) step(1'b1, 8'd128);
    step(1'b1, 8'd255);
    tests_run++;
    if (no_signal !== 1'b0 || meas_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL cross_wins_edge got ns=%b mv=%b want ns=0 mv=0", no_signal, meas_valid);
    end
    for (int n = 0; n < 49; n++) step(1'b1, 8'd255);
    for (int n = 0; n < 50; n++) step(1'b1, 8'd0);
    step(1'b1, 8'd255);
    tests_run++;
    if (meas_valid !== 1'b1 || period !== 24'd100 || vmax !== 8'd255 || vmin !== 8'd0) begin
      tests_failed++;
      $display("FAIL cross_wins_meas got mv=%b p=%0d max=%0d min=%0d want mv=1 p=100 max=255 min=0",
               meas_valid, period, vmax, vmin);
    end
  endtask

  task automatic test_midreset();
    logic exp;
    do_reset();
    for (int idx = 0; idx <= 220; idx++) step(1'b1, sq(idx, 50));
    tests_run++;
    if (period !== 24'd100) begin
      tests_failed++; $display("FAIL midreset_pre got p=%0d want 100", period);
    end
    sys_rst = 1'b1;
    step(1'b1, 8'd255);
    sys_rst = 1'b0;
    tests_run++;
    if (meas_valid !== 1'b0 || period !== 24'd0 || vmax !== 8'd0 || vmin !== 8'd0 ||
        no_signal !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear got mv=%b p=%0d max=%0d min=%0d ns=%b want all 0",
               meas_valid, period, vmax, vmin, no_signal);
    end
    for (int idx = 221; idx < 400; idx++) begin
      step(1'b1, sq(idx, 50));
      exp = (idx == 350);
      tests_run++;
      if (meas_valid !== exp) begin
        tests_failed++;
        $display("FAIL midreset_valid idx=%0d got %b want %b", idx, meas_valid, exp);
      end
      if (exp) begin
        tests_run++;
        if (period !== 24'd100 || vmax !== 8'd255 || vmin !== 8'd0) begin
          tests_failed++;
          $display("FAIL midreset_meas got p=%0d max=%0d min=%0d want p=100 max=255 min=0",
                   period, vmax, vmin);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_sawtooth();
    test_noise();
    test_sparse_en();
    test_timeout();
    test_cross_wins();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
